// File: rtl/ps2_keyboard_decoder.sv
`timescale 1ns/1ps
// ps2_keyboard_decoder
//   Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data lines, decodes
//   set-2 scancodes and emits single-cycle edit events for input_buffer.
//   Only the keys the function plotter accepts are mapped to ASCII; every other
//   key is dropped.
//
// Ports
//   clk          in   system clock (25.175 MHz)
//   rst          in   asynchronous active-high reset
//   ps2_clk      in   raw PS/2 clock, asynchronous to clk
//   ps2_data     in   raw PS/2 data, asynchronous to clk
//   left         out  1-cycle pulse: cursor left
//   right        out  1-cycle pulse: cursor right
//   backspace    out  1-cycle pulse: delete symbol
//   symbol       out  ASCII code held for one cycle, 0 otherwise
//   frame_error  out  1-cycle pulse: bad start/parity/stop or timeout
//
// Event outputs carry no handshake: each is a registered one-cycle pulse in the
// cycle after the frame's stop bit is accepted; the consumer latches it.
// Receiver state is visible as the 'state' signal (IDLE = 0).
module ps2_keyboard_decoder #(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES = 50350
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    output logic                    left,
    output logic                    right,
    output logic                    backspace,
    output logic [SYMBOL_WIDTH-1:0] symbol,
    output logic                    frame_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    rx_state_t   state;
    logic        clk_s1, clk_s2, clk_prev;
    logic        data_s1, data_s2;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        par_bit;
    logic [15:0] tcnt;
    logic        ext, brk, shift;

    logic        fall_edge;
    logic        timeout;
    logic        stop_edge;
    logic        frame_ok;
    logic        byte_valid;
    logic        frame_fail;
    logic        is_shift_key;

    logic [6:0]  dec_ascii;
    logic        dec_left, dec_right, dec_bs;

    assign fall_edge  = clk_prev & ~clk_s2;
    // The counter saturates at TIMEOUT_VAL, so the abandon fires only while a
    // frame is in progress and is released once the FSM is back in IDLE.
    assign timeout    = (state != IDLE) && (tcnt == TIMEOUT_VAL);
    assign stop_edge  = fall_edge && (state == STOP) && !timeout;
    // Odd parity over the 8 data bits plus the parity bit, and stop bit = 1.
    assign frame_ok   = data_s2 && (^{shreg, par_bit});
    assign byte_valid = stop_edge && frame_ok;
    assign frame_fail = timeout || (stop_edge && !frame_ok);
    assign is_shift_key = !ext && ((shreg == 8'h12) || (shreg == 8'h59));

    // Scancode to event map for the byte held in shreg, under current ext/shift.
    always_comb begin
        dec_ascii = 7'h00;
        dec_left  = 1'b0;
        dec_right = 1'b0;
        dec_bs    = 1'b0;
        if (ext) begin
            case (shreg)
                8'h6B:   dec_left  = 1'b1;
                8'h74:   dec_right = 1'b1;
                8'h4A:   dec_ascii = 7'h2F;
                8'h79:   dec_ascii = 7'h2B;
                default: dec_ascii = 7'h00;
            endcase
        end else begin
            case (shreg)
                8'h66: dec_bs    = 1'b1;
                8'h36: dec_ascii = shift ? 7'h5E : 7'h36;
                8'h3E: dec_ascii = shift ? 7'h2A : 7'h38;
                8'h46: dec_ascii = shift ? 7'h28 : 7'h39;
                8'h45: dec_ascii = shift ? 7'h29 : 7'h30;
                8'h55: dec_ascii = shift ? 7'h2B : 7'h00;
                8'h4E: dec_ascii = shift ? 7'h00 : 7'h2D;
                8'h4A: dec_ascii = shift ? 7'h00 : 7'h2F;
                8'h49: dec_ascii = shift ? 7'h00 : 7'h2E;
                8'h22: dec_ascii = shift ? 7'h00 : 7'h78;
                8'h16: dec_ascii = shift ? 7'h00 : 7'h31;
                8'h1E: dec_ascii = shift ? 7'h00 : 7'h32;
                8'h26: dec_ascii = shift ? 7'h00 : 7'h33;
                8'h25: dec_ascii = shift ? 7'h00 : 7'h34;
                8'h2E: dec_ascii = shift ? 7'h00 : 7'h35;
                8'h3D: dec_ascii = shift ? 7'h00 : 7'h37;
                // Keypad: shift has no effect.
                8'h70: dec_ascii = 7'h30;
                8'h69: dec_ascii = 7'h31;
                8'h72: dec_ascii = 7'h32;
                8'h7A: dec_ascii = 7'h33;
                8'h6B: dec_ascii = 7'h34;
                8'h73: dec_ascii = 7'h35;
                8'h74: dec_ascii = 7'h36;
                8'h6C: dec_ascii = 7'h37;
                8'h75: dec_ascii = 7'h38;
                8'h7D: dec_ascii = 7'h39;
                8'h79: dec_ascii = 7'h2B;
                8'h7B: dec_ascii = 7'h2D;
                8'h7C: dec_ascii = 7'h2A;
                8'h71: dec_ascii = 7'h2E;
                default: dec_ascii = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            clk_prev    <= 1'b1;
            data_s1     <= 1'b1;
            data_s2     <= 1'b1;
            shreg       <= 8'h00;
            bit_cnt     <= 3'd0;
            par_bit     <= 1'b0;
            tcnt        <= 16'd0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            shift       <= 1'b0;
            left        <= 1'b0;
            right       <= 1'b0;
            backspace   <= 1'b0;
            symbol      <= '0;
            frame_error <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;

            if (fall_edge)
                tcnt <= 16'd0;
            else if (tcnt != TIMEOUT_VAL)
                tcnt <= tcnt + 16'd1;

            left        <= 1'b0;
            right       <= 1'b0;
            backspace   <= 1'b0;
            symbol      <= '0;
            frame_error <= 1'b0;

            // Receiver
            if (timeout) begin
                state <= IDLE;
            end else if (fall_edge) begin
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s2;
                        state   <= STOP;
                    end
                    STOP: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            // Scancode decoder
            if (byte_valid) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (is_shift_key) begin
                        shift <= ~brk;
                    end else if (!brk) begin
                        left      <= dec_left;
                        right     <= dec_right;
                        backspace <= dec_bs;
                        symbol    <= SYMBOL_WIDTH'(dec_ascii);
                    end
                end
            end

            if (frame_fail) begin
                frame_error <= 1'b1;
                ext         <= 1'b0;
                brk         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
`timescale 1ns/1ps
module tb_ps2_keyboard_decoder;
  localparam int SW   = 7;
  localparam int TO   = 50350;
  localparam int HALF = 8;   // ps2_clk half period in clk cycles

  typedef struct {
    logic [7:0] code;
    logic [1:0] kind;        // 0 good, 1 bad parity, 2 bad stop
    logic [6:0] sym;
    logic       l;
    logic       r;
    logic       bs;
    logic       fe;
  } vec_t;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;
  logic left, right, backspace, frame_error;
  logic [SW-1:0] symbol;

  always #20 clk = ~clk;

  ps2_keyboard_decoder #(.SYMBOL_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .left(left),
    .right(right),
    .backspace(backspace),
    .symbol(symbol),
    .frame_error(frame_error)
  );

  // scoreboard: monitor counts pulse cycles on the falling clk edge
  int n_l = 0, n_r = 0, n_bs = 0, n_fe = 0, n_sym = 0, n_multi = 0;
  logic [SW-1:0] last_sym = '0;

  always @(negedge clk) begin
    if (left) n_l <= n_l + 1;
    if (right) n_r <= n_r + 1;
    if (backspace) n_bs <= n_bs + 1;
    if (frame_error) n_fe <= n_fe + 1;
    if (symbol != '0) begin
      n_sym <= n_sym + 1;
      last_sym <= symbol;
    end
    if (int'(left) + int'(right) + int'(backspace) + int'(symbol != '0) > 1)
      n_multi <= n_multi + 1;
  end

  int checks = 0;
  int errors = 0;
  int s_l, s_r, s_bs, s_fe, s_sym;
  vec_t vecs[64];
  int n_vec = 0;

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] kind);
    logic p;
    p = ~^b;
    if (kind == 2'd1) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(kind == 2'd2 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    wait_clks(12);
  endtask

  task automatic snap();
    s_l = n_l; s_r = n_r; s_bs = n_bs; s_fe = n_fe; s_sym = n_sym;
  endtask

  task automatic check_events(input string name, input logic [6:0] es,
                              input logic el, input logic er, input logic ebs, input logic efe);
    int dl, dr, dbs, dfe, dsym, esym;
    logic ok;
    dl = n_l - s_l; dr = n_r - s_r; dbs = n_bs - s_bs; dfe = n_fe - s_fe; dsym = n_sym - s_sym;
    esym = (es != 7'h00) ? 1 : 0;
    ok = (dl == int'(el)) && (dr == int'(er)) && (dbs == int'(ebs)) && (dfe == int'(efe))
         && (dsym == esym) && ((esym == 0) || (last_sym == es)) && (symbol == '0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got l=%0d r=%0d bs=%0d fe=%0d sym_cycles=%0d sym=%h now=%h, want l=%0d r=%0d bs=%0d fe=%0d sym_cycles=%0d sym=%h now=00",
               name, dl, dr, dbs, dfe, dsym, last_sym, symbol, el, er, ebs, efe, esym, es);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (dut.state != 2'd0 || left || right || backspace || frame_error || symbol != '0) begin
      errors++;
      $display("FAIL %s: got state=%0d l=%b r=%b bs=%b fe=%b sym=%h, want state=0 and all outputs 0",
               name, dut.state, left, right, backspace, frame_error, symbol);
    end
  endtask

  task automatic add(input logic [7:0] code, input logic [1:0] kind, input logic [6:0] sym,
                     input logic l, input logic r, input logic bs, input logic fe);
    vecs[n_vec] = '{code, kind, sym, l, r, bs, fe};
    n_vec++;
  endtask

  initial begin
    // vector table: one frame per entry, expected events after that frame
    add(8'h16, 0, 7'h31, 0, 0, 0, 0);   // '1'
    add(8'h16, 0, 7'h31, 0, 0, 0, 0);   // typematic repeat
    add(8'h12, 0, 7'h00, 0, 0, 0, 0);   // left shift down
    add(8'h46, 0, 7'h28, 0, 0, 0, 0);   // '('
    add(8'hF0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h46, 0, 7'h00, 0, 0, 0, 0);   // break: nothing
    add(8'hF0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h12, 0, 7'h00, 0, 0, 0, 0);   // shift up
    add(8'h46, 0, 7'h39, 0, 0, 0, 0);   // '9'
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h6B, 0, 7'h00, 1, 0, 0, 0);   // left
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h74, 0, 7'h00, 0, 1, 0, 0);   // right
    add(8'h66, 0, 7'h00, 0, 0, 1, 0);   // backspace
    add(8'h22, 1, 7'h00, 0, 0, 0, 1);   // bad parity
    add(8'h22, 0, 7'h78, 0, 0, 0, 0);   // 'x'
    add(8'h22, 2, 7'h00, 0, 0, 0, 1);   // bad stop
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h22, 1, 7'h00, 0, 0, 0, 1);   // error clears ext
    add(8'h6B, 0, 7'h34, 0, 0, 0, 0);   // keypad '4'
    add(8'h59, 0, 7'h00, 0, 0, 0, 0);   // right shift down
    add(8'h66, 0, 7'h00, 0, 0, 1, 0);   // backspace with shift
    add(8'h55, 0, 7'h2B, 0, 0, 0, 0);   // '+'
    add(8'h4E, 0, 7'h00, 0, 0, 0, 0);
    add(8'h7C, 0, 7'h2A, 0, 0, 0, 0);   // keypad '*'
    add(8'h3E, 0, 7'h2A, 0, 0, 0, 0);   // '*'
    add(8'h36, 0, 7'h5E, 0, 0, 0, 0);   // '^'
    add(8'h45, 0, 7'h29, 0, 0, 0, 0);   // ')'
    add(8'h16, 0, 7'h00, 0, 0, 0, 0);   // shifted digit: nothing
    add(8'hF0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h59, 0, 7'h00, 0, 0, 0, 0);   // shift up
    add(8'h55, 0, 7'h00, 0, 0, 0, 0);
    add(8'h4E, 0, 7'h2D, 0, 0, 0, 0);   // '-'
    add(8'h36, 0, 7'h36, 0, 0, 0, 0);   // '6'
    add(8'h7A, 0, 7'h33, 0, 0, 0, 0);   // keypad '3'
    add(8'h71, 0, 7'h2E, 0, 0, 0, 0);   // keypad '.'
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h4A, 0, 7'h2F, 0, 0, 0, 0);   // keypad '/'
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h79, 0, 7'h2B, 0, 0, 0, 0);   // extended '+'
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h1F, 0, 7'h00, 0, 0, 0, 0);   // unlisted extended
    add(8'h49, 0, 7'h2E, 0, 0, 0, 0);   // '.'
    add(8'hE0, 0, 7'h00, 0, 0, 0, 0);
    add(8'hF0, 0, 7'h00, 0, 0, 0, 0);
    add(8'h6B, 0, 7'h00, 0, 0, 0, 0);   // extended break
    add(8'h6B, 0, 7'h34, 0, 0, 0, 0);
    add(8'h1C, 0, 7'h00, 0, 0, 0, 0);   // unlisted
    add(8'h3D, 0, 7'h37, 0, 0, 0, 0);   // '7'
    add(8'h25, 0, 7'h34, 0, 0, 0, 0);   // '4'

    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    check_idle("reset");
    rst = 1'b0;
    wait_clks(5);
    check_idle("after_reset");

    for (int i = 0; i < n_vec; i++) begin
      snap();
      send_frame(vecs[i].code, vecs[i].kind);
      check_events($sformatf("vec%0d_%h", i, vecs[i].code), vecs[i].sym,
                   vecs[i].l, vecs[i].r, vecs[i].bs, vecs[i].fe);
    end

    // partial frame abandoned by timeout
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    wait_clks(TO + 10);
    check_events("timeout", 7'h00, 0, 0, 0, 1);
    check_idle("timeout_idle");
    snap();
    send_frame(8'h45, 0);
    check_events("after_timeout_45", 7'h30, 0, 0, 0, 0);

    // reset mid-frame after an E0 prefix
    send_frame(8'hE0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(3);
    check_idle("mid_frame_reset");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    snap();
    send_frame(8'h6B, 0);
    check_events("after_reset_6B", 7'h34, 0, 0, 0, 0);

    checks++;
    if (n_multi != 0) begin
      errors++;
      $display("FAIL one_event: got %0d cycles with several events, want 0", n_multi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
